// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//
// Shares one common data bus (CDB) among N_SRC execution units. Every source
// owns a small private FIFO; a round-robin arbiter drains at most one FIFO head
// per cycle into a registered broadcast that goes to the ROB and the
// reservation stations. A flush (mispredict) discards everything in flight.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   flush        synchronous discard of all pending results
//   src_valid    per-source result valid
//   src_rob_id   per-source tag, source i at [i*ROB_BIT +: ROB_BIT]
//   src_data     per-source result, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ready    per-source FIFO can accept (registered count only)
//   cdb_en       broadcast valid
//   cdb_rob_id   broadcast tag
//   cdb_data     broadcast value
//   cdb_src      index of the granted source
//   busy         any FIFO non-empty

module cdb_arbiter #(
    parameter int N_SRC      = 3,
    parameter int ROB_BIT    = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [N_SRC-1:0]              src_valid,
    input  logic [N_SRC*ROB_BIT-1:0]      src_rob_id,
    input  logic [N_SRC*DATA_WIDTH-1:0]   src_data,
    output logic [N_SRC-1:0]              src_ready,
    output logic                          cdb_en,
    output logic [ROB_BIT-1:0]            cdb_rob_id,
    output logic [DATA_WIDTH-1:0]         cdb_data,
    output logic [1:0]                    cdb_src,
    output logic                          busy
);

    localparam int          PTR_W    = $clog2(FIFO_DEPTH);
    localparam int          CNT_W    = PTR_W + 1;
    localparam logic [1:0]  LAST_RST = 2'(N_SRC - 1);

    // FIFO storage and bookkeeping
    logic [ROB_BIT-1:0]    r_mem_rob  [N_SRC][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [N_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr     [N_SRC];
    logic [PTR_W-1:0]      r_rptr     [N_SRC];
    logic [CNT_W-1:0]      r_cnt      [N_SRC];

    // Arbiter and broadcast registers
    logic [1:0]            r_last_grant;
    logic                  r_cdb_en;
    logic [ROB_BIT-1:0]    r_cdb_rob_id;
    logic [DATA_WIDTH-1:0] r_cdb_data;
    logic [1:0]            r_cdb_src;

    logic [N_SRC-1:0]      w_ready;
    logic [N_SRC-1:0]      w_nonempty;
    logic [N_SRC-1:0]      w_push;
    logic [N_SRC-1:0]      w_pop;
    logic                  w_grant_valid;
    logic [1:0]            w_grant_idx;
    logic [ROB_BIT-1:0]    w_head_rob;
    logic [DATA_WIDTH-1:0] w_head_data;

    // Ready comes only from the registered count: a pop in the same cycle does
    // not open the FIFO, which keeps ready free of any path from the arbiter.
    always_comb begin
        w_ready    = '0;
        w_nonempty = '0;
        w_push     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_ready[i]    = (r_cnt[i] < CNT_W'(FIFO_DEPTH));
            w_nonempty[i] = (r_cnt[i] != '0);
            w_push[i]     = src_valid[i] & w_ready[i];
        end
    end

    // Round-robin search starting one past the last winner, wrapping mod N_SRC.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            for (int j = 0; j < N_SRC; j++) begin
                if (!w_grant_valid && w_nonempty[j] &&
                    (j == ((int'(r_last_grant) + k) % N_SRC))) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = 2'(j);
                end
            end
        end
    end

    // Pop vector and head-of-winner mux
    always_comb begin
        w_pop       = '0;
        w_head_rob  = '0;
        w_head_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_grant_valid && (w_grant_idx == 2'(i))) begin
                w_pop[i]    = 1'b1;
                w_head_rob  = r_mem_rob[i][r_rptr[i]];
                w_head_data = r_mem_data[i][r_rptr[i]];
            end
        end
    end

    // Data storage carries no reset; validity lives entirely in the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (w_push[i]) begin
                r_mem_rob[i][r_wptr[i]]  <= src_rob_id[i*ROB_BIT +: ROB_BIT];
                r_mem_data[i][r_wptr[i]] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointers and counts; flush drops both the pushes and the pop of this cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + PTR_W'(1);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    // Broadcast register and round-robin pointer. Tag/data hold their last
    // value when idle or flushed; consumers look at cdb_en only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_en     <= 1'b0;
            r_cdb_rob_id <= '0;
            r_cdb_data   <= '0;
            r_cdb_src    <= '0;
            r_last_grant <= LAST_RST;
        end else if (flush) begin
            r_cdb_en     <= 1'b0;
            r_last_grant <= LAST_RST;
        end else begin
            r_cdb_en <= w_grant_valid;
            if (w_grant_valid) begin
                r_cdb_rob_id <= w_head_rob;
                r_cdb_data   <= w_head_data;
                r_cdb_src    <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
        end
    end

    assign src_ready  = w_ready;
    assign busy       = |w_nonempty;
    assign cdb_en     = r_cdb_en;
    assign cdb_rob_id = r_cdb_rob_id;
    assign cdb_data   = r_cdb_data;
    assign cdb_src    = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int RB = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [N-1:0]  src_valid;
    logic [N*RB-1:0] src_rob_id;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]  src_ready;
    logic          cdb_en;
    logic [RB-1:0] cdb_rob_id;
    logic [DW-1:0] cdb_data;
    logic [1:0]    cdb_src;
    logic          busy;

    always #5 clk = ~clk;

    cdb_arbiter #(.N_SRC(N), .ROB_BIT(RB), .DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_rob_id(src_rob_id), .src_data(src_data),
        .src_ready(src_ready),
        .cdb_en(cdb_en), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
        .cdb_src(cdb_src), .busy(busy)
    );

    typedef struct {
        int          src;
        int          cyc;
        logic [4:0]  rob;
        logic [31:0] data;
        bit          done;
    } item_t;

    typedef struct {
        logic [1:0]  src;
        logic [4:0]  rob;
        logic [31:0] data;
    } exp_t;

    item_t tbl[$];
    exp_t  exp_q[$];
    int    drv_idx[N];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic logic [31:0] dval(logic [4:0] tag);
        return {24'hC0DE00, 3'b000, tag};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_item(int s, int c, logic [4:0] tag);
        item_t it;
        it.src = s; it.cyc = c; it.rob = tag; it.data = dval(tag); it.done = 1'b0;
        tbl.push_back(it);
    endtask

    task automatic expect_bc(int s, logic [4:0] tag);
        exp_t e;
        e.src = 2'(s); e.rob = tag; e.data = dval(tag);
        exp_q.push_back(e);
    endtask

    // Present, per source, the oldest unsent item whose release cycle has come.
    task automatic drive(int c);
        src_valid  = '0;
        src_rob_id = '0;
        src_data   = '0;
        for (int s = 0; s < N; s++) begin
            drv_idx[s] = -1;
            for (int k = 0; k < tbl.size(); k++) begin
                if (!tbl[k].done && tbl[k].src == s && tbl[k].cyc <= c) begin
                    drv_idx[s] = k;
                    break;
                end
            end
            if (drv_idx[s] >= 0) begin
                src_valid[s]            = 1'b1;
                src_rob_id[s*RB +: RB]  = tbl[drv_idx[s]].rob;
                src_data[s*DW +: DW]    = tbl[drv_idx[s]].data;
            end
        end
    endtask

    // First half of a cycle: drive, move to the negedge, record handshakes.
    task automatic cyc_a(int c, output logic [N-1:0] acc);
        drive(c);
        @(negedge clk);
        acc = src_valid & src_ready;
        for (int s = 0; s < N; s++) begin
            if (acc[s]) tbl[drv_idx[s]].done = 1'b1;
        end
    endtask

    task automatic cyc_b();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        src_valid = '0;
        src_rob_id = '0;
        src_data  = '0;
        tbl.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_en"},    cdb_en,     0);
        check({tag, "_rob"},   cdb_rob_id, 0);
        check({tag, "_data"},  cdb_data,   0);
        check({tag, "_src"},   cdb_src,    0);
        check({tag, "_ready"}, src_ready,  3'b111);
        check({tag, "_busy"},  busy,       0);
    endtask

    // Scoreboard monitor: every broadcast must be the next expected result.
    always @(negedge clk) begin
        if (cdb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL cdb_extra: got src=%0d rob=%0d data=%0h, expected no broadcast",
                         cdb_src, cdb_rob_id, cdb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("cdb", {25'd0, cdb_src, cdb_rob_id, cdb_data}, {25'd0, e.src, e.rob, e.data});
            end
        end
    end

    initial begin
        logic [N-1:0] acc;

        // Test 1: reset state, single pulse from source 1 in cycle 3
        do_reset();
        check_reset_outputs("t1_reset");
        add_item(1, 3, 5'd5);
        tbl[0].data = 32'hDEADBEEF;
        begin
            exp_t e;
            e.src = 2'd1; e.rob = 5'd5; e.data = 32'hDEADBEEF;
            exp_q.push_back(e);
        end
        for (int c = 0; c < 8; c++) begin
            cyc_a(c, acc);
            check("t1_en",   cdb_en, (c == 5));
            check("t1_busy", busy,   (c == 4));
            cyc_b();
        end
        check("t1_drain", exp_q.size(), 0);

        // Test 2: all three push together, then a lone src0 push
        do_reset();
        add_item(0, 0, 5'd1);
        add_item(1, 0, 5'd2);
        add_item(2, 0, 5'd3);
        add_item(0, 4, 5'd4);
        expect_bc(0, 5'd1);
        expect_bc(1, 5'd2);
        expect_bc(2, 5'd3);
        expect_bc(0, 5'd4);
        for (int c = 0; c < 9; c++) begin
            cyc_a(c, acc);
            check("t2_en", cdb_en, (c == 2 || c == 3 || c == 4 || c == 6));
            cyc_b();
        end
        check("t2_drain", exp_q.size(), 0);

        // Test 3: src0 holds valid continuously, src1/src2 push two each
        do_reset();
        for (int t = 0; t < 6; t++) add_item(0, 0, 5'(8 + t));
        add_item(1, 0, 5'd16);
        add_item(1, 0, 5'd17);
        add_item(2, 0, 5'd24);
        add_item(2, 0, 5'd25);
        expect_bc(0, 5'd8);
        expect_bc(1, 5'd16);
        expect_bc(2, 5'd24);
        expect_bc(0, 5'd9);
        expect_bc(1, 5'd17);
        expect_bc(2, 5'd25);
        expect_bc(0, 5'd10);
        expect_bc(0, 5'd11);
        expect_bc(0, 5'd12);
        expect_bc(0, 5'd13);
        for (int c = 0; c < 14; c++) begin
            cyc_a(c, acc);
            if (c >= 2 && c <= 5) check("t3_ready0", src_ready[0], (c == 2 || c == 5));
            cyc_b();
        end
        check("t3_drain", exp_q.size(), 0);

        // Test 4: backpressure on source 2 while 0 and 1 stay busy
        do_reset();
        add_item(0, 0, 5'd1);
        add_item(0, 1, 5'd2);
        add_item(0, 2, 5'd3);
        add_item(1, 0, 5'd4);
        add_item(1, 1, 5'd5);
        add_item(1, 3, 5'd6);
        add_item(2, 0, 5'd7);
        add_item(2, 1, 5'd8);
        add_item(2, 2, 5'd9);
        expect_bc(0, 5'd1);
        expect_bc(1, 5'd4);
        expect_bc(2, 5'd7);
        expect_bc(0, 5'd2);
        expect_bc(1, 5'd5);
        expect_bc(2, 5'd8);
        expect_bc(0, 5'd3);
        expect_bc(1, 5'd6);
        expect_bc(2, 5'd9);
        for (int c = 0; c < 13; c++) begin
            cyc_a(c, acc);
            if (c >= 2 && c <= 4) check("t4_ready2", src_ready[2], (c == 4));
            if (c >= 2 && c <= 5) check("t4_accept2", acc[2], (c == 4));
            cyc_b();
        end
        check("t4_drain", exp_q.size(), 0);

        // Test 5: flush with FIFOs loaded and a push in the flush cycle
        do_reset();
        add_item(0, 0, 5'd1);
        add_item(0, 1, 5'd2);
        add_item(0, 2, 5'd3);
        add_item(0, 3, 5'd4);
        add_item(1, 0, 5'd5);
        add_item(1, 1, 5'd6);
        add_item(1, 3, 5'd7);
        add_item(2, 0, 5'd8);
        add_item(2, 1, 5'd9);
        add_item(2, 3, 5'd10);
        expect_bc(0, 5'd1);
        expect_bc(1, 5'd5);
        expect_bc(0, 5'd11);
        expect_bc(1, 5'd12);
        expect_bc(2, 5'd13);
        for (int c = 0; c < 11; c++) begin
            flush = (c == 3);
            cyc_a(c, acc);
            if (c == 3) begin
                check("t5_en_flushcyc", cdb_en, 1);
                tbl.delete();
                add_item(0, 4, 5'd11);
                add_item(1, 4, 5'd12);
                add_item(2, 4, 5'd13);
            end
            if (c == 4) begin
                check("t5_en",    cdb_en,    0);
                check("t5_busy",  busy,      0);
                check("t5_ready", src_ready, 3'b111);
            end
            cyc_b();
        end
        flush = 1'b0;
        check("t5_drain", exp_q.size(), 0);

        // Test 6: rst mid-stream with a broadcast in flight
        do_reset();
        add_item(0, 0, 5'd14);
        add_item(1, 0, 5'd15);
        add_item(2, 0, 5'd16);
        expect_bc(0, 5'd14);
        expect_bc(1, 5'd17);
        expect_bc(2, 5'd18);
        for (int c = 0; c < 10; c++) begin
            rst = (c == 2);
            cyc_a(c, acc);
            if (c == 2) begin
                check("t6_en_rstcyc", cdb_en, 1);
                tbl.delete();
                add_item(1, 4, 5'd17);
                add_item(2, 4, 5'd18);
            end
            if (c == 3) check_reset_outputs("t6_after_rst");
            cyc_b();
        end
        rst = 1'b0;
        check("t6_drain", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_final", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
